bsg_nasti_tunnel_arb: RTL and testbench
=======================================

Name: bsg_nasti_tunnel_arb

Overview:
- Shares one tunnel request/response channel pair among num_clients_p NASTI client front-ends.
- Request side: round-robin arbitration at packet granularity; a multi-beat packet (e.g. write address + data beats) is never interleaved with another client's packet.
- Response side: routes returning packets to the originating client by source tag.
- Per-client outstanding-request credit counter throttles clients that have too many responses pending.

Parameters:
- num_clients_p, 2, number of requesting clients (>=2).
- data_width_p, 64, width of one tunnel beat.
- max_outstanding_p, 4, maximum response-bearing packets pending per client (>=1).
- src_width_p, `BSG_SAFE_CLOG2(num_clients_p), width of the source tag.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- cl_req_valid_i  in  num_clients_p  per-client request beat valid.
- cl_req_data_i  in  num_clients_p*data_width_p  per-client beat data; client k occupies slice k.
- cl_req_last_i  in  num_clients_p  marks the final beat of a packet.
- cl_req_expect_resp_i  in  num_clients_p  packet produces one response packet; sampled on the last beat.
- cl_req_yumi_o  out  num_clients_p  beat consumed from client k.
- req_valid_o  out  1  tunnel request valid.
- req_data_o  out  data_width_p  tunnel request data.
- req_src_o  out  src_width_p  index of the owning client.
- req_last_o  out  1  final beat of the packet.
- req_yumi_i  in  1  tunnel consumed the beat.
- resp_valid_i  in  1  tunnel response beat valid.
- resp_data_i  in  data_width_p  response data.
- resp_src_i  in  src_width_p  destination client.
- resp_last_i  in  1  final response beat.
- resp_yumi_o  out  1  response beat consumed.
- cl_resp_valid_o  out  num_clients_p  one-hot response valid.
- cl_resp_data_o  out  data_width_p  response data, broadcast to all clients.
- cl_resp_last_o  out  1  response last, broadcast.
- cl_resp_ready_i  in  num_clients_p  per-client response ready.

Behaviour:
- Reset (reset_n_i=0, asynchronous):
  - state=IDLE, rr_ptr=0, owner=0, all credit counters=0.
  - All *_valid_o and *_yumi_o are forced to 0 while reset is asserted.
- Eligibility in IDLE: client k is eligible iff cl_req_valid_i[k] and cnt[k] < max_outstanding_p.
- Grant in IDLE: the first eligible client scanning rr_ptr, rr_ptr+1, ... modulo num_clients_p. The grant is combinational, so a packet can start with zero added latency.
- Forwarding: req_valid_o, req_data_o, req_last_o and req_src_o reflect the granted client.
  - cl_req_yumi_o[g] = req_yumi_i & req_valid_o.
  - Every other cl_req_yumi_o bit stays 0.
- IDLE transitions:
  - Yumi on a beat with last=0: go to LOCKED, owner<=g.
  - Yumi on a beat with last=1: stay in IDLE, rr_ptr<=(g+1) mod num_clients_p.
  - No yumi: no state change. The grant may change next cycle if the valids change.
- LOCKED:
  - Only the owner is forwarded; the credit check is skipped.
  - req_valid_o = cl_req_valid_i[owner]. Owner bubbles are passed through and other clients are never granted.
  - Yumi on a beat with last=1: go to IDLE, rr_ptr<=(owner+1) mod num_clients_p.
- Credit counters:
  - cnt[k] increments on a yumi of client k's last beat when cl_req_expect_resp_i[k]=1.
  - cnt[k] decrements on resp_yumi_o & resp_last_i with resp_src_i==k.
  - Increment and decrement in the same cycle: cnt is unchanged.
  - Decrement at cnt=0: cnt held at 0 (no underflow). The beat is still delivered.
  - The counter width must hold max_outstanding_p exactly.
- Response routing (stateless; may complete in the same cycle it is presented):
  - For resp_src_i < num_clients_p: cl_resp_valid_o = resp_valid_i << resp_src_i, and resp_yumi_o = resp_valid_i & cl_resp_ready_i[resp_src_i].
  - For resp_src_i >= num_clients_p: resp_yumi_o = resp_valid_i (beat dropped), and all cl_resp_valid_o bits are 0.
- Request and response paths are independent; simultaneous activity on both is legal.
- Reset asserted mid-packet: LOCKED is abandoned and the partial packet is discarded by this block. Clients must also be reset.

Test Plan:
- Clients 0 and 1 each send a 1-beat packet continuously, req_yumi_i=1 always -> req_src_o alternates 0,1,0,1; each cl_req_yumi_o bit pulses every other cycle.
- Client 0 sends a 3-beat packet (last on beat 3) while client 1 is valid throughout; req_yumi_i toggles 1,0,1,0,1 -> all 3 client-0 beats are forwarded first, then client 1's beat.
- max_outstanding_p=2; client 0 sends 3 expect_resp packets with no responses returned -> the third is blocked with cnt[0]=2. Return one response with resp_src_i=0 and resp_last_i=1 -> the third packet is granted the following cycle.
- Same-cycle credit: client 0 last-beat yumi with expect_resp=1 while a response to client 0 is consumed -> cnt[0] is unchanged.
- Response with resp_src_i=1 and cl_resp_ready_i=2'b00 -> cl_resp_valid_o=2'b10 and resp_yumi_o=0. Raise ready[1] -> yumi is asserted. Response with resp_src_i=3 when num_clients_p=3 -> immediately consumed with all cl_resp_valid_o bits 0.
- Assert reset_n_i=0 during the second beat of a LOCKED packet -> outputs drop to 0 asynchronously. After release: state=IDLE, rr_ptr=0, all counters 0.

Source files
------------

// File: rtl/bsg_nasti_tunnel_arb.sv
// Packet-granular round-robin arbiter that shares one tunnel request/response pair
// among several NASTI clients, with per-client outstanding-response credit throttling.

module bsg_nasti_tunnel_arb_credit #(
  parameter int max_p = 4,
  parameter int cnt_w = 3
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic ok_o
);
  logic [cnt_w-1:0] cnt_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                                         cnt_r <= '0;
    else if (inc_i && !dec_i && cnt_r != cnt_w'(max_p))     cnt_r <= cnt_r + 1'b1;
    else if (dec_i && !inc_i && cnt_r != '0)                cnt_r <= cnt_r - 1'b1;
  end

  assign ok_o = (cnt_r < cnt_w'(max_p));
endmodule

module bsg_nasti_tunnel_arb #(
  parameter int num_clients_p     = 2,
  parameter int data_width_p      = 64,
  parameter int max_outstanding_p = 4,
  parameter int src_width_p       = (num_clients_p <= 1) ? 1 : $clog2(num_clients_p)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_clients_p-1:0]              cl_req_valid_i,
  input  logic [num_clients_p*data_width_p-1:0] cl_req_data_i,
  input  logic [num_clients_p-1:0]              cl_req_last_i,
  input  logic [num_clients_p-1:0]              cl_req_expect_resp_i,
  output logic [num_clients_p-1:0]              cl_req_yumi_o,
  output logic                                  req_valid_o,
  output logic [data_width_p-1:0]               req_data_o,
  output logic [src_width_p-1:0]                req_src_o,
  output logic                                  req_last_o,
  input  logic                                  req_yumi_i,
  input  logic                                  resp_valid_i,
  input  logic [data_width_p-1:0]               resp_data_i,
  input  logic [src_width_p-1:0]                resp_src_i,
  input  logic                                  resp_last_i,
  output logic                                  resp_yumi_o,
  output logic [num_clients_p-1:0]              cl_resp_valid_o,
  output logic [data_width_p-1:0]               cl_resp_data_o,
  output logic                                  cl_resp_last_o,
  input  logic [num_clients_p-1:0]              cl_resp_ready_i
);
  localparam int cnt_w = $clog2(max_outstanding_p + 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                   state_r, state_n;
  logic [src_width_p-1:0]   rr_ptr_r, rr_ptr_n, owner_r, owner_n;
  logic [num_clients_p-1:0] credit_ok, cnt_inc, cnt_dec;
  logic [src_width_p-1:0]   grant, sel;
  logic                     grant_v, sel_v, sel_last, req_fire;
  logic                     src_ok, ready_sel, resp_fire;

  // state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= IDLE;
      rr_ptr_r <= '0;
      owner_r  <= '0;
    end else begin
      state_r  <= state_n;
      rr_ptr_r <= rr_ptr_n;
      owner_r  <= owner_n;
    end
  end

  // Scan backwards so the last hit is the first eligible client from rr_ptr.
  always_comb begin
    grant_v = 1'b0;
    grant   = rr_ptr_r;
    for (int i = num_clients_p - 1; i >= 0; i--) begin
      int s;
      s = int'(rr_ptr_r) + i;
      if (s >= num_clients_p) s = s - num_clients_p;
      if (cl_req_valid_i[s] && credit_ok[s]) begin
        grant_v = 1'b1;
        grant   = src_width_p'(s);
      end
    end
  end

  assign sel      = (state_r == LOCKED) ? owner_r : grant;
  assign sel_v    = (state_r == LOCKED) ? cl_req_valid_i[owner_r] : grant_v;
  assign sel_last = cl_req_last_i[sel];
  assign req_fire = req_valid_o & req_yumi_i;

  // next-state logic
  always_comb begin
    state_n  = state_r;
    rr_ptr_n = rr_ptr_r;
    owner_n  = owner_r;
    if (req_fire) begin
      if (sel_last) begin
        state_n  = IDLE;
        rr_ptr_n = (sel == src_width_p'(num_clients_p - 1)) ? '0 : sel + 1'b1;
      end else if (state_r == IDLE) begin
        state_n = LOCKED;
        owner_n = sel;
      end
    end
  end

  // request-side outputs; valids/yumis are held low during reset
  always_comb begin
    req_valid_o   = reset_n_i & sel_v;
    req_src_o     = sel;
    req_last_o    = sel_last;
    req_data_o    = '0;
    cl_req_yumi_o = '0;
    for (int k = 0; k < num_clients_p; k++) begin
      if (sel == src_width_p'(k)) begin
        req_data_o       = cl_req_data_i[k*data_width_p +: data_width_p];
        cl_req_yumi_o[k] = req_fire;
      end
    end
  end

  // Response routing is stateless; out-of-range tags are consumed and dropped.
  assign src_ok = (32'(resp_src_i) < 32'(num_clients_p));

  always_comb begin
    ready_sel       = 1'b0;
    cl_resp_valid_o = '0;
    for (int k = 0; k < num_clients_p; k++) begin
      if (resp_src_i == src_width_p'(k)) begin
        ready_sel          = cl_resp_ready_i[k];
        cl_resp_valid_o[k] = reset_n_i & resp_valid_i;
      end
    end
  end

  assign resp_yumi_o    = reset_n_i & resp_valid_i & (src_ok ? ready_sel : 1'b1);
  assign resp_fire      = resp_yumi_o & resp_last_i & src_ok;
  assign cl_resp_data_o = resp_data_i;
  assign cl_resp_last_o = resp_last_i;

  for (genvar k = 0; k < num_clients_p; k++) begin : g_credit
    assign cnt_inc[k] = cl_req_yumi_o[k] & cl_req_last_i[k] & cl_req_expect_resp_i[k];
    assign cnt_dec[k] = resp_fire & (resp_src_i == src_width_p'(k));

    bsg_nasti_tunnel_arb_credit #(
      .max_p (max_outstanding_p),
      .cnt_w (cnt_w)
    ) u_credit (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .inc_i     (cnt_inc[k]),
      .dec_i     (cnt_dec[k]),
      .ok_o      (credit_ok[k])
    );
  end
endmodule

// File: tb/tb_bsg_nasti_tunnel_arb.sv
// Scoreboard bench for bsg_nasti_tunnel_arb: 3 clients, 2 credits each, 16-bit beats.

module tb_bsg_nasti_tunnel_arb;
  localparam int N  = 3;
  localparam int DW = 16;
  localparam int M  = 2;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    cl_req_valid, cl_req_last, cl_req_exp, cl_req_yumi;
  logic [N*DW-1:0] cl_req_data;
  logic            req_valid, req_last, req_yumi;
  logic [DW-1:0]   req_data;
  logic [SW-1:0]   req_src;
  logic            resp_valid, resp_last, resp_yumi;
  logic [DW-1:0]   resp_data;
  logic [SW-1:0]   resp_src;
  logic [N-1:0]    cl_resp_valid, cl_resp_ready;
  logic [DW-1:0]   cl_resp_data;
  logic            cl_resp_last;

  typedef struct packed {logic [SW-1:0] src; logic [DW-1:0] data; logic last;} req_t;
  typedef struct packed {logic [N-1:0] vld; logic [DW-1:0] data; logic last;} resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic [11:0] tag;

  always #5 clk = ~clk;

  bsg_nasti_tunnel_arb #(
    .num_clients_p(N), .data_width_p(DW), .max_outstanding_p(M), .src_width_p(SW)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .cl_req_valid_i(cl_req_valid), .cl_req_data_i(cl_req_data), .cl_req_last_i(cl_req_last),
    .cl_req_expect_resp_i(cl_req_exp), .cl_req_yumi_o(cl_req_yumi),
    .req_valid_o(req_valid), .req_data_o(req_data), .req_src_o(req_src), .req_last_o(req_last),
    .req_yumi_i(req_yumi),
    .resp_valid_i(resp_valid), .resp_data_i(resp_data), .resp_src_i(resp_src),
    .resp_last_i(resp_last), .resp_yumi_o(resp_yumi),
    .cl_resp_valid_o(cl_resp_valid), .cl_resp_data_o(cl_resp_data), .cl_resp_last_o(cl_resp_last),
    .cl_resp_ready_i(cl_resp_ready)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int k, input logic [11:0] t);
    logic [3:0] kk;
    kk = 4'(k);
    return {kk, t};
  endfunction

  task automatic drive_data();
    for (int k = 0; k < N; k++) cl_req_data[k*DW +: DW] = beat_data(k, tag);
  endtask

  task automatic push_req(input int src, input logic last);
    req_t e;
    e.src = SW'(src); e.data = beat_data(src, tag); e.last = last;
    req_q.push_back(e);
  endtask

  task automatic push_resp(input logic [N-1:0] vld);
    resp_t e;
    e.vld = vld; e.data = resp_data; e.last = resp_last;
    resp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    tag = tag + 12'd1;
    drive_data();
  endtask

  task automatic resp_drive(input logic v, input int src, input logic [N-1:0] rdy);
    resp_valid = v; resp_src = SW'(src); resp_last = 1'b1;
    resp_data = {4'hE, tag}; cl_resp_ready = rdy;
  endtask

  // Monitor: pops the scoreboard whenever a beat actually transfers.
  always @(negedge clk) begin
    if (req_valid && req_yumi) begin
      if (req_q.size() == 0) chk("req_unexpected", 32'({req_src, req_data, req_last}), 32'h0);
      else chk("req_beat", 32'({req_src, req_data, req_last}), 32'(req_q.pop_front()));
    end
    if (resp_valid && resp_yumi) begin
      if (resp_q.size() == 0) chk("resp_unexpected", 32'({cl_resp_valid, cl_resp_data, cl_resp_last}), 32'h0);
      else chk("resp_beat", 32'({cl_resp_valid, cl_resp_data, cl_resp_last}), 32'(resp_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int yumi_t[6];
    int beat_t[6];
    yumi_t = '{1, 0, 1, 0, 1, 1};
    beat_t = '{1, 2, 2, 3, 3, 0};
    tag = '0;
    reset_n = 1'b0;
    cl_req_valid = '1; cl_req_last = '1; cl_req_exp = '0; req_yumi = 1'b1;
    drive_data();
    resp_drive(1'b1, 0, '1);
    #2;
    chk("rst_req_valid", 32'(req_valid), 0);
    chk("rst_req_yumi", 32'(cl_req_yumi), 0);
    chk("rst_resp_yumi", 32'(resp_yumi), 0);
    chk("rst_resp_valid", 32'(cl_resp_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    resp_drive(1'b0, 0, '0);
    cl_req_valid = '0;
    reset_n = 1'b1;
    tick();

    // alternating 1-beat packets from clients 0 and 1
    cl_req_valid = 3'b011; cl_req_last = 3'b111; req_yumi = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_req(i % 2, 1'b1);
      @(negedge clk);
      chk("alt_yumi", 32'(cl_req_yumi), 32'(1 << (i % 2)));
      tick();
    end

    // 3-beat packet from client 0 is not interleaved with client 1
    for (int c = 0; c < 6; c++) begin
      cl_req_valid = {1'b0, 1'b1, beat_t[c] != 0};
      cl_req_last  = {2'b11, beat_t[c] == 3};
      req_yumi     = (yumi_t[c] != 0);
      if (req_yumi) push_req(c < 5 ? 0 : 1, c < 5 ? (beat_t[c] == 3) : 1'b1);
      @(negedge clk);
      chk("lock_src", 32'(req_src), c < 5 ? 0 : 1);
      chk("lock_yumi1", 32'(cl_req_yumi[1]), (c == 5) ? 1 : 0);
      tick();
    end

    // credit throttling on client 0
    cl_req_valid = 3'b001; cl_req_last = 3'b111; cl_req_exp = 3'b001; req_yumi = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c < 2) push_req(0, 1'b1);
      @(negedge clk);
      chk("credit_valid", 32'(req_valid), c < 2 ? 1 : 0);
      tick();
    end
    resp_drive(1'b1, 0, 3'b001);
    push_resp(3'b001);
    @(negedge clk);
    chk("credit_blk_resp", 32'(req_valid), 0);
    chk("credit_resp_vld", 32'(cl_resp_valid), 3'b001);
    tick();
    resp_drive(1'b0, 0, '0);
    push_req(0, 1'b1);
    @(negedge clk);
    chk("credit_regrant", 32'(req_valid), 1);
    tick();

    // same-cycle increment and decrement leave the count unchanged
    cl_req_valid = 3'b000;
    resp_drive(1'b1, 0, 3'b001); push_resp(3'b001);
    tick();
    cl_req_valid = 3'b001;
    resp_drive(1'b1, 0, 3'b001); push_resp(3'b001); push_req(0, 1'b1);
    @(negedge clk);
    chk("same_cyc_grant", 32'(req_valid), 1);
    tick();
    resp_drive(1'b0, 0, '0); push_req(0, 1'b1);
    @(negedge clk);
    chk("same_cyc_next", 32'(req_valid), 1);
    tick();
    @(negedge clk);
    chk("same_cyc_block", 32'(req_valid), 0);
    tick();
    cl_req_valid = 3'b000;
    for (int c = 0; c < 2; c++) begin
      resp_drive(1'b1, 0, 3'b001); push_resp(3'b001);
      tick();
    end

    // response routing: backpressure, release, out-of-range tag
    resp_drive(1'b1, 1, 3'b000);
    @(negedge clk);
    chk("route_vld", 32'(cl_resp_valid), 3'b010);
    chk("route_stall", 32'(resp_yumi), 0);
    tick();
    resp_drive(1'b1, 1, 3'b010); push_resp(3'b010);
    @(negedge clk);
    chk("route_yumi", 32'(resp_yumi), 1);
    tick();
    resp_drive(1'b1, 3, 3'b000); push_resp(3'b000);
    @(negedge clk);
    chk("drop_yumi", 32'(resp_yumi), 1);
    chk("drop_vld", 32'(cl_resp_valid), 0);
    tick();
    resp_drive(1'b0, 0, '0);

    // client 1 counter held at 0 by the stray decrement: exactly two packets fit
    cl_req_valid = 3'b010; cl_req_exp = 3'b010;
    for (int c = 0; c < 3; c++) begin
      if (c < 2) push_req(1, 1'b1);
      @(negedge clk);
      chk("no_underflow", 32'(req_valid), c < 2 ? 1 : 0);
      tick();
    end

    // reset in the middle of a locked packet
    cl_req_valid = 3'b100; cl_req_last = 3'b011; cl_req_exp = 3'b000;
    push_req(2, 1'b0);
    tick();
    resp_drive(1'b1, 0, '1);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_req_valid", 32'(req_valid), 0);
    chk("midrst_req_yumi", 32'(cl_req_yumi), 0);
    chk("midrst_resp_yumi", 32'(resp_yumi), 0);
    chk("midrst_resp_vld", 32'(cl_resp_valid), 0);
    tick();
    resp_drive(1'b0, 0, '0);
    cl_req_valid = '0;
    reset_n = 1'b1;
    tick();

    // after reset: rr from 0, IDLE, all counters empty (two credits each)
    cl_req_valid = 3'b111; cl_req_last = 3'b111; cl_req_exp = 3'b111;
    for (int c = 0; c < 8; c++) begin
      if (c < 6) push_req(c % 3, 1'b1);
      @(negedge clk);
      chk("post_rst_valid", 32'(req_valid), c < 6 ? 1 : 0);
      tick();
    end
    cl_req_valid = '0; req_yumi = 1'b0;
    tick();
    chk("req_q_empty", 32'(req_q.size()), 0);
    chk("resp_q_empty", 32'(resp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
